// File: rtl/bram_pair_add_seq_if.sv
// Bus bundle between the pair-add sequencer and its two BRAMs.
// master = sequencer side, slave = memories/controller side.
interface bram_pair_add_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              start;
  logic              dir_up;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_dout;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W:0]   out_din;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] carry_cnt;

  modport master (
    input  start, dir_up, in_dout,
    output in_addr, out_we, out_addr, out_din,
    output busy, done, carry_cnt
  );

  modport slave (
    output start, dir_up, in_dout,
    input  in_addr, out_we, out_addr, out_din,
    input  busy, done, carry_cnt
  );
endinterface

// File: rtl/bram_pair_add_seq.sv
// Pair-add sequencer: reads word pairs from the input BRAM, writes sums.
// Define PAIR_ADD_SIGNED_EN for two's complement operands and overflow.
module bram_pair_add_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input logic                clk,
  input logic                reset,
  bram_pair_add_seq_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_B = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LASTP = ADDR_W'(DEPTH / 2 - 1);
  localparam logic [ADDR_W-1:0] CMAX = '1;
  localparam logic [1:0]        LAT  = 2'(RD_LAT);

  logic [2:0]        state;
  logic [1:0]        lat_cnt;
  logic              up;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] pair_cnt;
  logic [DATA_W-1:0] a;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W:0]   wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] carry;

  logic [DATA_W:0]   ext_a;
  logic [DATA_W:0]   ext_b;
  logic [DATA_W:0]   sum;
  logic              ovf;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] lo_addr;
  logic              lat_end;

  always_comb begin
`ifdef PAIR_ADD_SIGNED_EN
    ext_a = {a[DATA_W-1], a};
    ext_b = {bus.in_dout[DATA_W-1], bus.in_dout};
    sum   = ext_a + ext_b;
    ovf   = sum[DATA_W] ^ sum[DATA_W-1];
`else
    ext_a = {1'b0, a};
    ext_b = {1'b0, bus.in_dout};
    sum   = ext_a + ext_b;
    ovf   = sum[DATA_W];
`endif
  end

  // addr always holds the word being read, so in RD_B it is B's address
  assign next_addr = up ? addr + 1'b1 : addr - 1'b1;
  assign lo_addr   = (addr_a < addr) ? addr_a : addr;
  assign lat_end   = (lat_cnt == LAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      up       <= 1'b1;
      addr     <= '0;
      addr_a   <= '0;
      pair_cnt <= '0;
      a        <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      carry    <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            up       <= bus.dir_up;
            carry    <= '0;
            addr     <= bus.dir_up ? '0 : TOP;
            lat_cnt  <= '0;
            pair_cnt <= '0;
            busy     <= 1'b1;
            state    <= RD_A;
          end
        end
        RD_A: begin
          if (lat_end) begin
            a       <= bus.in_dout;
            addr_a  <= addr;
            addr    <= next_addr;
            lat_cnt <= '0;
            state   <= RD_B;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RD_B: begin
          if (lat_end) begin
            we      <= 1'b1;
            wdata   <= sum;
            waddr   <= lo_addr >> 1;
            lat_cnt <= '0;
            if (ovf && carry != CMAX)
              carry <= carry + 1'b1;
            state   <= WR;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        WR: begin
          // terminal pair: leave addr on the last word, no step past the end
          if (pair_cnt == LASTP) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pair_cnt <= pair_cnt + 1'b1;
            addr     <= next_addr;
            state    <= RD_A;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_addr   = addr;
  assign bus.out_we    = we;
  assign bus.out_addr  = waddr;
  assign bus.out_din   = wdata;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.carry_cnt = carry;

endmodule

// File: tb/tb_bram_pair_add_seq.sv
// Directed bench for bram_pair_add_seq with RD_LAT=1 and RD_LAT=2 BRAM models.
// Expected sums and cycle counts are hand-derived per pass.
module tb_bram_pair_add_seq;

  localparam int NP = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bram_pair_add_seq_if #(.DATA_W(8), .ADDR_W(6)) u_if ();
  bram_pair_add_seq_if #(.DATA_W(8), .ADDR_W(6)) u_if2 ();

  bram_pair_add_seq #(
    .DATA_W(8), .ADDR_W(6), .DEPTH(64), .RD_LAT(1)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(u_if.master)
  );

  bram_pair_add_seq #(
    .DATA_W(8), .ADDR_W(6), .DEPTH(64), .RD_LAT(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .bus(u_if2.master)
  );

  logic [7:0] mem [64];
  logic [7:0] p1, p2a, p2b;

  always @(posedge clk) begin
    p1  <= mem[u_if.in_addr];
    p2a <= mem[u_if2.in_addr];
    p2b <= p2a;
  end
  assign u_if.in_dout  = p1;
  assign u_if2.in_dout = p2b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0 = 0, c0_2 = 0;
  int wr_idx = 0, wr_idx2 = 0;
  int last_we = -1, last_we2 = -1;
  int done_cyc = -1, done2_cyc = -1;
  bit exp_up = 1'b1;
  logic [8:0] exp_out [NP];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.out_we === 1'b1) begin
      check("wr_addr", 32'(u_if.out_addr),
            exp_up ? 32'(wr_idx) : 32'(NP - 1 - wr_idx));
      check("wr_data", 32'(u_if.out_din), 32'(exp_out[u_if.out_addr]));
      wr_idx++;
      last_we = cyc - c0 + 1;
    end
    if (u_if.done === 1'b1) begin
      done_cyc = cyc - c0 + 1;
      check("busy_in_done", 32'(u_if.busy), 0);
    end
    if (u_if2.out_we === 1'b1) begin
      check("wr2_data", 32'(u_if2.out_din), 32'(exp_out[u_if2.out_addr]));
      wr_idx2++;
      last_we2 = cyc - c0_2 + 1;
    end
    if (u_if2.done === 1'b1) done2_cyc = cyc - c0_2 + 1;
  end

  task automatic check_idle(input string p);
    check({p, "_in_addr"}, 32'(u_if.in_addr), 0);
    check({p, "_out_addr"}, 32'(u_if.out_addr), 0);
    check({p, "_out_din"}, 32'(u_if.out_din), 0);
    check({p, "_carry"}, 32'(u_if.carry_cnt), 0);
    check({p, "_we"}, 32'(u_if.out_we), 0);
    check({p, "_busy"}, 32'(u_if.busy), 0);
    check({p, "_done"}, 32'(u_if.done), 0);
  endtask

  task automatic start_pass(input bit up, input bit both);
    @(negedge clk);
    exp_up = up;
    wr_idx = 0; wr_idx2 = 0;
    last_we = -1; last_we2 = -1;
    done_cyc = -1; done2_cyc = -1;
    u_if.start = 1'b1; u_if.dir_up = up;
    if (both) begin
      u_if2.start = 1'b1; u_if2.dir_up = up;
    end
    @(posedge clk);
    #1;
    c0 = cyc; c0_2 = cyc;
    check("busy_after_start", 32'(u_if.busy), 1);
    @(negedge clk);
    u_if.start = 1'b0; u_if2.start = 1'b0;
    u_if.dir_up = ~up;
  endtask

  task automatic wait_done(input string p);
    for (int i = 0; i < 2000 && done_cyc < 0; i++) @(posedge clk);
    check({p, "_done_seen"}, 32'(done_cyc >= 0), 1);
    @(negedge clk);
    check({p, "_done_pulse"}, 32'(u_if.done), 0);
    check({p, "_busy_end"}, 32'(u_if.busy), 0);
  endtask

  task automatic fill_ramp;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    for (int k = 0; k < NP; k++) exp_out[k] = 9'(4 * k + 1);
  endtask

  initial begin
    u_if.start = 1'b0; u_if.dir_up = 1'b1;
    u_if2.start = 1'b0; u_if2.dir_up = 1'b1;
    fill_ramp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check_idle("rst");

    // ascending pass
    start_pass(1'b1, 1'b0);
    wait_done("up");
    check("up_writes", wr_idx, NP);
    check("up_last_we", last_we, 160);
    check("up_done_cyc", done_cyc, 161);
    check("up_carry", 32'(u_if.carry_cnt), 0);

    // descending pass, same contents
    start_pass(1'b0, 1'b0);
    wait_done("dn");
    check("dn_writes", wr_idx, NP);
    check("dn_last_we", last_we, 160);
    check("dn_done_cyc", done_cyc, 161);

    // all 0xFF, both latencies
    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
    for (int k = 0; k < NP; k++) exp_out[k] = 9'h1FE;
    start_pass(1'b1, 1'b1);
    wait_done("ff");
    check("ff_writes", wr_idx, NP);
`ifdef PAIR_ADD_SIGNED_EN
    check("ff_carry", 32'(u_if.carry_cnt), 0);
`else
    check("ff_carry", 32'(u_if.carry_cnt), 32);
`endif
    for (int i = 0; i < 500 && done2_cyc < 0; i++) @(posedge clk);
    @(negedge clk);
    check("lat2_writes", wr_idx2, NP);
    check("lat2_last_we", last_we2, 224);
    check("lat2_done_cyc", done2_cyc, 225);

    // signed-boundary pairs
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h80; mem[1] = 8'hFF;
    mem[2] = 8'h7F; mem[3] = 8'h81;
    for (int k = 0; k < NP; k++) exp_out[k] = 9'h000;
    exp_out[0] = 9'h17F;
`ifdef PAIR_ADD_SIGNED_EN
    exp_out[1] = 9'h000;
`else
    exp_out[1] = 9'h100;
`endif
    start_pass(1'b1, 1'b0);
    wait_done("sg");
`ifdef PAIR_ADD_SIGNED_EN
    check("sg_carry", 32'(u_if.carry_cnt), 1);
`else
    check("sg_carry", 32'(u_if.carry_cnt), 2);
`endif

    // start while busy, then reset mid-pass
    fill_ramp();
    start_pass(1'b1, 1'b0);
    u_if.start = 1'b1; u_if.dir_up = 1'b0;
    @(negedge clk);
    u_if.start = 1'b0;
    for (int i = 0; i < 200 && wr_idx < 3; i++) @(posedge clk);
    check("mid_three_writes", wr_idx, 3);
    #2 reset = 1'b1;
    #1 check_idle("mid_rst");
    repeat (10) @(negedge clk);
    check("mid_no_we", wr_idx, 3);
    check("mid_no_done", done_cyc, -1);
    reset = 1'b0;
    start_pass(1'b1, 1'b0);
    wait_done("re");
    check("re_writes", wr_idx, NP);
    check("re_last_we", last_we, 160);
    check("re_done_cyc", done_cyc, 161);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
